matmul_requester: RTL and testbench

Issue-side controller for the 2x2 8-bit matrix-multiply unit. It accepts a multiply request from the execute stage on a valid/ready handshake and drives the unit's start pulse and operands. It detects completion on the unit's level-type done, with a timeout, and returns the packed result plus destination tag to writeback on a second valid/ready handshake. One request is in flight at a time; the pipeline stalls through `req_ready` while the block is busy.

---
 rtl/matmul_requester_pkg.sv | 19 +
 rtl/matmul_requester_if.sv | 34 +++
 rtl/matmul_requester.sv | 130 +++++++++++++
 tb/tb_matmul_requester.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/matmul_requester_pkg.sv
// Shared definitions for the 2x2 8-bit matrix-multiply issue path.
// Element offsets are common to the requester and the multiply unit.
package mm_pkg;

   localparam int MM_WORD_W  = 32;
   localparam int MM_ELEM_W  = 8;
   localparam int MM_A00_OFF = 0;
   localparam int MM_A01_OFF = 8;
   localparam int MM_A10_OFF = 16;
   localparam int MM_A11_OFF = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } mm_req_state_t;

endpackage

// File: rtl/matmul_requester_if.sv
// Request, multiply-unit and response signals of the matmul requester.
// slave is the requester's view; master is the surrounding pipeline/unit.
interface matmul_requester_if #(
   parameter int DEST_W = 3
);
   import mm_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [MM_WORD_W-1:0] req_a;
   logic [MM_WORD_W-1:0] req_b;
   logic [DEST_W-1:0]    req_dest;
   logic                 mm_start;
   logic [MM_WORD_W-1:0] mm_a;
   logic [MM_WORD_W-1:0] mm_b;
   logic [MM_WORD_W-1:0] mm_c;
   logic                 mm_done;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [MM_WORD_W-1:0] rsp_data;
   logic [DEST_W-1:0]    rsp_dest;
   logic                 rsp_err;

   modport slave (
      input  req_valid, req_a, req_b, req_dest, mm_c, mm_done, rsp_ready,
      output req_ready, mm_start, mm_a, mm_b, rsp_valid, rsp_data, rsp_dest, rsp_err
   );

   modport master (
      output req_valid, req_a, req_b, req_dest, mm_c, mm_done, rsp_ready,
      input  req_ready, mm_start, mm_a, mm_b, rsp_valid, rsp_data, rsp_dest, rsp_err
   );

endinterface

// File: rtl/matmul_requester.sv
// Issue-side controller for the 2x2 matrix-multiply unit: one request in
// flight, start pulse, filtered level-done with timeout, tagged response.
module matmul_requester
   import mm_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int DEST_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   matmul_requester_if.slave  bus,
   output logic               busy,
   output logic [15:0]        op_cnt
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   mm_req_state_t        state_q, state_d;
   logic                 req_ready_q, req_ready_d;
   logic                 mm_start_q, mm_start_d;
   logic [MM_WORD_W-1:0] mm_a_q, mm_a_d;
   logic [MM_WORD_W-1:0] mm_b_q, mm_b_d;
   logic [DEST_W-1:0]    dest_q, dest_d;
   logic                 seen_low_q, seen_low_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [MM_WORD_W-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 busy_q, busy_d;
   logic [15:0]          op_cnt_q, op_cnt_d;

   always_comb begin
      state_d    = state_q;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      dest_d     = dest_q;
      seen_low_d = seen_low_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      op_cnt_d   = op_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               mm_a_d  = bus.req_a;
               mm_b_d  = bus.req_b;
               dest_d  = bus.req_dest;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            seen_low_d = 1'b0;
            cnt_d      = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            if (!bus.mm_done) seen_low_d = 1'b1;
            // done only counts once it has been seen low since the start;
            // a real completion beats a timeout landing on the same cycle
            if (seen_low_q && bus.mm_done) begin
               rsp_data_d = bus.mm_c;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               if (!rsp_err_q && op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // status outputs are registered copies of the next state
      mm_start_d  = (state_d == ISSUE);
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         mm_start_q  <= 1'b0;
         mm_a_q      <= '0;
         mm_b_q      <= '0;
         dest_q      <= '0;
         seen_low_q  <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         op_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         mm_start_q  <= mm_start_d;
         mm_a_q      <= mm_a_d;
         mm_b_q      <= mm_b_d;
         dest_q      <= dest_d;
         seen_low_q  <= seen_low_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.mm_start  = mm_start_q;
   assign bus.mm_a      = mm_a_q;
   assign bus.mm_b      = mm_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_dest  = dest_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;
   assign op_cnt        = op_cnt_q;

endmodule

// File: tb/tb_matmul_requester.sv
// Randomised bench for matmul_requester with a behavioural multiply unit
// (configurable done-clear and compute delays, optional hang).
module tb_matmul_requester;
   import mm_pkg::*;

   localparam int T  = 16;
   localparam int DW = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy;
   logic [15:0] op_cnt;

   matmul_requester_if #(.DEST_W(DW)) bus ();

   matmul_requester #(.TIMEOUT(T), .DEST_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .op_cnt(op_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0] exp_ops = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Reference 2x2 product, elements wrap mod 256.
   function automatic logic [31:0] mat_mul(input logic [31:0] a, input logic [31:0] b);
      int m[2][2];
      int n[2][2];
      logic [31:0] r;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            m[i][j] = int'(a[(2*i+j)*8 +: 8]);
            n[i][j] = int'(b[(2*i+j)*8 +: 8]);
         end
      r = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            r[(2*i+j)*8 +: 8] = 8'(m[i][0]*n[0][j] + m[i][1]*n[1][j]);
      return r;
   endfunction

   // Unit model: done drops u_clr edges after the start edge, rises u_cmp later.
   int          u_clr = 0;
   int          u_cmp = 1;
   bit          u_hang = 1'b0;
   bit          u_act = 1'b0;
   int          u_t = 0;
   logic [31:0] u_c = '0;
   logic        u_done = 1'b0;
   logic [31:0] u_cdata = '0;

   assign bus.mm_done = u_done;
   assign bus.mm_c    = u_cdata;

   always @(posedge clk) begin
      if (bus.mm_start) begin
         u_act <= 1'b1;
         u_t   <= 1;
         u_c   <= mat_mul(bus.mm_a, bus.mm_b);
         if (u_clr == 0) u_done <= 1'b0;
      end else if (u_act) begin
         u_t <= u_t + 1;
         if (u_t == u_clr) u_done <= 1'b0;
         if (!u_hang && u_t == u_clr + u_cmp) begin
            u_done  <= 1'b1;
            u_cdata <= u_c;
            u_act   <= 1'b0;
         end
      end
   end

   task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [DW-1:0] d,
                          input int clr, input int cmp, input bit hang, input int hold,
                          input bit poke);
      int          lat;
      int          t;
      int          starts;
      bit          held;
      bit          stable;
      bit          exp_err;
      logic [31:0] exp_c;
      logic [31:0] d0;
      exp_err = hang || (clr + cmp > T - 1);
      lat     = exp_err ? T + 1 : 2 + clr + cmp;
      exp_c   = exp_err ? 32'h0 : mat_mul(a, b);
      u_clr = clr; u_cmp = cmp; u_hang = hang;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_dest = d;
      t = 0;
      while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
      chk("req_ready", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_a = $urandom; bus.req_b = $urandom;
      chk("start_pulse", bus.mm_start, 1);
      chk("ready_low", bus.req_ready, 0);
      chk("busy", busy, 1);
      chk("mm_a", bus.mm_a, a);
      chk("mm_b", bus.mm_b, b);
      starts = 1; held = 1'b1; t = 0;
      while (!bus.rsp_valid && t < 3*T) begin
         @(negedge clk); t++;
         if (bus.mm_start) starts++;
         if (bus.mm_a !== a || bus.mm_b !== b) held = 1'b0;
      end
      chk("latency", 64'(t), 64'(lat));
      chk("start_cnt", 64'(starts), 1);
      chk("operand_hold", held, 1);
      chk("rsp_data", bus.rsp_data, exp_c);
      chk("rsp_err", bus.rsp_err, exp_err);
      chk("rsp_dest", bus.rsp_dest, d);
      d0 = bus.rsp_data; stable = 1'b1;
      if (poke) begin bus.req_valid = 1'b1; bus.req_a = $urandom; end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.req_ready || bus.mm_start) stable = 1'b0;
      end
      if (hold > 0) chk("rsp_hold", stable, 1);
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      if (!exp_err && exp_ops != 16'hFFFF) exp_ops++;
      chk("rsp_drop", bus.rsp_valid, 0);
      chk("idle_ready", bus.req_ready, 1);
      chk("busy_idle", busy, 0);
      chk("op_cnt", op_cnt, exp_ops);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, bus.req_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_start"}, bus.mm_start, 0);
      chk({tag, "_rspv"}, bus.rsp_valid, 0);
      chk({tag, "_data"}, bus.rsp_data, 0);
      chk({tag, "_err"}, bus.rsp_err, 0);
      chk({tag, "_dest"}, bus.rsp_dest, 0);
      chk({tag, "_mma"}, bus.mm_a, 0);
      chk({tag, "_opcnt"}, op_cnt, 0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_dest = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", bus.req_ready, 1);

      run_req(32'h04030201, 32'h01000001, 3'd5, 0, 1, 1'b0, 0, 1'b0);
      run_req(32'h10101010, 32'h10101010, 3'd2, 0, 1, 1'b0, 0, 1'b0);
      run_req(32'h08070605, 32'h04030201, 3'd7, 2, 5, 1'b0, 0, 1'b0);
      run_req(32'h11223344, 32'h55667788, 3'd1, 0, 1, 1'b1, 0, 1'b0);
      run_req(32'h01020304, 32'h05060708, 3'd3, 0, 15, 1'b0, 0, 1'b0);
      run_req(32'h0A0B0C0D, 32'h01010101, 3'd4, 0, 16, 1'b0, 0, 1'b0);
      run_req(32'hFFFEFDFC, 32'h02030405, 3'd6, 0, 1, 1'b0, 10, 1'b1);

      // reset while the unit is still computing
      u_clr = 0; u_cmp = 4; u_hang = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_a = 32'h01010101; bus.req_b = 32'h02020202; bus.req_dest = 3'd3;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      exp_ops = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run_req(32'h04030201, 32'h02010102, 3'd6, 2, 2, 1'b0, 0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         run_req($urandom, $urandom, DW'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 6)), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
